// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming SECDED (8,4) codeword layout, types and encoder function
package hamming_pkg;

    localparam int P1   = 0;
    localparam int P2   = 1;
    localparam int D0   = 2;
    localparam int P4   = 3;
    localparam int D1   = 4;
    localparam int D2   = 5;
    localparam int D3   = 6;
    localparam int PALL = 7;

    typedef logic [7:0] codeword_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic codeword_t hamming_enc(logic [3:0] d);
        codeword_t cw;
        cw[D0]   = d[0];
        cw[D1]   = d[1];
        cw[D2]   = d[2];
        cw[D3]   = d[3];
        cw[P1]   = d[0] ^ d[1] ^ d[3];
        cw[P2]   = d[0] ^ d[2] ^ d[3];
        cw[P4]   = d[1] ^ d[2] ^ d[3];
        // Overall parity makes the full 8-bit word even, enabling double-error detection.
        cw[PALL] = ^cw[6:0];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_tx_serial_encoder.sv
// rtl/hamming_tx_serial_encoder.sv - combinational Hamming (8,4) encoder wrapper
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [3:0] data,
    output codeword_t  codeword
);

    assign codeword = hamming_enc(data);

endmodule

// File: rtl/hamming_tx_serial.sv
// rtl/hamming_tx_serial.sv - Hamming (8,4) encoder with error injection and framed serial transmitter
module hamming_tx_serial
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [3:0] i_data,
    input  logic [7:0] i_err_mask,
    output logic       o_ready,
    output logic       o_tx,
    output logic [7:0] o_codeword,
    output logic       o_done
);

    localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

    tx_state_t state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    codeword_t  shreg_q, shreg_d;
    codeword_t  cw_q, cw_d;
    logic       tx_q, tx_d;
    codeword_t  enc_cw;
    logic       baud_last;

    hamming_encoder u_enc (
        .data     (i_data),
        .codeword (enc_cw)
    );

    assign baud_last  = (baud_q == BAUD_MAX);
    assign o_ready    = (state_q == IDLE);
    assign o_tx       = tx_q;
    assign o_codeword = cw_q;
    assign o_done     = (state_q == STOP) && baud_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= 8'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            cw_q    <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cw_q    <= cw_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line level for the cycle after this edge, so each state
    // transition also loads the level the new state drives.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        cw_d    = cw_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                baud_d = 8'd0;
                bit_d  = 3'd0;
                tx_d   = 1'b1;
                if (i_valid) begin
                    state_d = START;
                    shreg_d = enc_cw ^ i_err_mask;
                    cw_d    = enc_cw ^ i_err_mask;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = 8'd0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = 8'd0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Bit 0 stays in place while it is on the line, so the
                        // next bit to send is always shreg_q[1] before the shift.
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = 8'd0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_hamming_tx_serial.sv
// tb/tb_hamming_tx_serial.sv - directed self-checking bench for hamming_tx_serial
module tb_hamming_tx_serial;

    logic       clk = 1'b0;
    logic       rst;

    logic       valid4, ready4, tx4, done4;
    logic [3:0] data4;
    logic [7:0] mask4, cw4;

    logic       valid1, ready1, tx1, done1;
    logic [3:0] data1;
    logic [7:0] mask1, cw1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] enc_tab [16] = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
                                 8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};

    always #5 clk = ~clk;

    hamming_tx_serial #(.CLKS_PER_BIT(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (valid4),
        .i_data     (data4),
        .i_err_mask (mask4),
        .o_ready    (ready4),
        .o_tx       (tx4),
        .o_codeword (cw4),
        .o_done     (done4)
    );

    hamming_tx_serial #(.CLKS_PER_BIT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (valid1),
        .i_data     (data1),
        .i_err_mask (mask1),
        .o_ready    (ready1),
        .o_tx       (tx1),
        .o_codeword (cw1),
        .o_done     (done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid4 = 1'b0; data4 = 4'h0; mask4 = 8'h00;
        valid1 = 1'b0; data1 = 4'h0; mask1 = 8'h00;
        step();
        step();
        n_cmp++;
        if ({tx4, ready4, cw4, done4} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset4: tx/ready/cw/done got %b/%b/%h/%b want 1/1/00/0", tx4, ready4, cw4, done4);
        end
        n_cmp++;
        if ({tx1, ready1, cw1, done1} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset1: tx/ready/cw/done got %b/%b/%h/%b want 1/1/00/0", tx1, ready1, cw1, done1);
        end
        rst = 1'b0;
        step();
    endtask

    // One CLKS_PER_BIT=4 frame: accept, then 40 cycles of line/done/ready capture.
    task automatic frame4(input logic [3:0] d, input logic [7:0] m, input logic [7:0] exp_cw, input string name);
        logic [39:0] got_tx, got_done, got_rdy, exp_tx;
        n_cmp++;
        if (ready4 !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before: got %b want 1", name, ready4);
        end
        valid4 = 1'b1; data4 = d; mask4 = m;
        step();
        valid4 = 1'b0; data4 = 4'($urandom); mask4 = 8'($urandom);
        n_cmp++;
        if (cw4 !== exp_cw) begin
            n_err++;
            $display("FAIL %s codeword: got %h want %h", name, cw4, exp_cw);
        end
        for (int k = 1; k <= 40; k++) begin
            int slot;
            slot = (k - 1) / 4;
            exp_tx[k-1] = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : exp_cw[slot-1];
            got_tx[k-1]   = tx4;
            got_done[k-1] = done4;
            got_rdy[k-1]  = ready4;
            step();
        end
        n_cmp++;
        if (got_tx !== exp_tx) begin
            n_err++;
            $display("FAIL %s line: got %h want %h", name, got_tx, exp_tx);
        end
        n_cmp++;
        if (got_done !== (40'h1 << 39)) begin
            n_err++;
            $display("FAIL %s done: got %h want %h", name, got_done, 40'h1 << 39);
        end
        n_cmp++;
        if (got_rdy !== 40'h0) begin
            n_err++;
            $display("FAIL %s ready_during: got %h want 0", name, got_rdy);
        end
        n_cmp++;
        if ({ready4, tx4, cw4} !== {1'b1, 1'b1, exp_cw}) begin
            n_err++;
            $display("FAIL %s after: ready/tx/cw got %b/%b/%h want 1/1/%h", name, ready4, tx4, cw4, exp_cw);
        end
    endtask

    task automatic test_basic_frames();
        frame4(4'b0010, 8'h00, 8'b1001_1001, "enc_0010");
        frame4(4'b0010, 8'b0000_0100, 8'b1001_1101, "mask_bit2");
        frame4(4'b1111, 8'h00, 8'hFF, "enc_1111");
        frame4(4'b0000, 8'h00, 8'h00, "enc_0000");
    endtask

    task automatic test_back_to_back();
        int rdy_high;
        int waited;
        rdy_high = 0;
        valid4 = 1'b1; data4 = 4'b0101; mask4 = 8'h00;
        step();
        data4 = 4'b1111;
        for (int k = 1; k <= 40; k++) begin
            if (ready4 === 1'b1) rdy_high++;
            step();
        end
        n_cmp++;
        if (rdy_high != 0 || cw4 !== 8'h2D) begin
            n_err++;
            $display("FAIL b2b_hold: ready_high_cycles %0d cw %h want 0 2d", rdy_high, cw4);
        end
        n_cmp++;
        if (ready4 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready41: got %b want 1", ready4);
        end
        step();
        n_cmp++;
        if ({ready4, cw4} !== {1'b0, 8'hFF}) begin
            n_err++;
            $display("FAIL b2b_second_accept: ready/cw got %b/%h want 0/ff", ready4, cw4);
        end
        valid4 = 1'b0;
        waited = 0;
        while (ready4 !== 1'b1 && waited < 60) begin
            step();
            waited++;
        end
        n_cmp++;
        if (ready4 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_drain: ready got %b want 1 within 60 cycles", ready4);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_seen;
        done_seen = 0;
        valid4 = 1'b1; data4 = 4'b0010; mask4 = 8'h00;
        step();
        valid4 = 1'b0;
        // cycles 17..20 carry data bit 3
        for (int k = 1; k < 18; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({tx4, ready4, cw4, done4} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL midreset: tx/ready/cw/done got %b/%b/%h/%b want 1/1/00/0", tx4, ready4, cw4, done4);
        end
        for (int k = 0; k < 30; k++) begin
            if (done4 === 1'b1) done_seen++;
            step();
        end
        n_cmp++;
        if (done_seen != 0 || tx4 !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_quiet: done pulses %0d tx %b want 0 1", done_seen, tx4);
        end
        frame4(4'b1010, 8'h00, 8'hD2, "after_reset");
    endtask

    task automatic test_reset_vs_valid();
        rst = 1'b1;
        valid4 = 1'b1; data4 = 4'b1111; mask4 = 8'h00;
        step();
        rst = 1'b0;
        valid4 = 1'b0;
        n_cmp++;
        if ({tx4, ready4, cw4} !== {1'b1, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL rst_wins: tx/ready/cw got %b/%b/%h want 1/1/00", tx4, ready4, cw4);
        end
        step();
        n_cmp++;
        if ({tx4, ready4} !== 2'b11) begin
            n_err++;
            $display("FAIL rst_wins_idle: tx/ready got %b/%b want 1/1", tx4, ready4);
        end
    endtask

    // CLKS_PER_BIT=1 frame; returns the 8 data bits recovered from the line.
    task automatic frame1(input logic [3:0] d, input logic [7:0] m, output logic [7:0] rx,
                          output logic framing_ok);
        logic [9:0] line, dn;
        valid1 = 1'b1; data1 = d; mask1 = m;
        step();
        valid1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            line[k] = tx1;
            dn[k]   = done1;
            step();
        end
        rx = line[8:1];
        framing_ok = (line[0] === 1'b0) && (line[9] === 1'b1) && (dn === 10'b10_0000_0000) && (ready1 === 1'b1);
    endtask

    task automatic test_all_words_cpb1();
        logic [7:0] rx;
        logic ok;
        for (int d = 0; d < 16; d++) begin
            frame1(4'(d), 8'h00, rx, ok);
            n_cmp++;
            if (cw1 !== enc_tab[d] || rx !== enc_tab[d] || !ok) begin
                n_err++;
                $display("FAIL cpb1_d%0d: cw %h rx %h framing %b want %h %h 1", d, cw1, rx, ok, enc_tab[d], enc_tab[d]);
            end
        end
    endtask

    task automatic test_loopback_single_errors();
        logic [7:0] rx, fixed;
        logic [2:0] syn;
        logic ok, overall;
        logic [3:0] d, dec;
        for (int k = 0; k < 8; k++) begin
            d = 4'((k * 5 + 3) % 16);
            frame1(d, 8'h01 << k, rx, ok);
            // syndrome over 1-based positions 1..7 = cw[0]..cw[6]
            syn[0]  = rx[0] ^ rx[2] ^ rx[4] ^ rx[6];
            syn[1]  = rx[1] ^ rx[2] ^ rx[5] ^ rx[6];
            syn[2]  = rx[3] ^ rx[4] ^ rx[5] ^ rx[6];
            overall = ^rx;
            fixed = rx;
            if (overall) begin
                if (syn != 3'd0) fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
                else fixed[7] = ~fixed[7];
            end
            dec = {fixed[6], fixed[5], fixed[4], fixed[2]};
            n_cmp++;
            if (rx !== (enc_tab[d] ^ (8'h01 << k)) || overall !== 1'b1 || dec !== d || !ok) begin
                n_err++;
                $display("FAIL loopback_bit%0d: rx %h corrected %b data %h framing %b want %h 1 %h 1",
                         k, rx, overall, dec, ok, enc_tab[d] ^ (8'h01 << k), d);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_vs_valid();
        test_all_words_cpb1();
        test_loopback_single_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
